// File: rtl/comp_result_merger_pkg.sv
// Shared widths for the compression datapath.
// Host words are an integer number of core beats wide.
package common;
  localparam int COMP_CORES     = 4;
  localparam int COMP_DATA_BITS = 128;
  localparam int AXI_DATA_BITS  = 512;
  localparam int COMP_RATIO     = AXI_DATA_BITS / COMP_DATA_BITS;
endpackage

// File: rtl/comp_result_merger_packer.sv
// axis_lane_packer: packs narrow AXIS beats into wide words.
// A word closes on its last lane or on tlast, never mixing packets.
module axis_lane_packer #(
  parameter int IN_BITS  = 128,
  parameter int OUT_BITS = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_BITS-1:0]    s_tdata_i,
  input  logic [IN_BITS/8-1:0]  s_tkeep_i,
  input  logic                  s_tlast_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [OUT_BITS-1:0]   m_tdata_o,
  output logic [OUT_BITS/8-1:0] m_tkeep_o,
  output logic                  m_tlast_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i
);
  localparam int RATIO = OUT_BITS / IN_BITS;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int KB    = IN_BITS / 8;

  logic [LW-1:0]         lane_q, lane_d;
  logic [OUT_BITS-1:0]   pack_data_q, pack_data_d;
  logic [OUT_BITS/8-1:0] pack_keep_q, pack_keep_d;
  logic [OUT_BITS-1:0]   out_data_q, out_data_d;
  logic [OUT_BITS/8-1:0] out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0]   word_data;
  logic [OUT_BITS/8-1:0] word_keep;
  logic                  completes, out_free, accept;

  assign completes  = (lane_q == LW'(RATIO - 1)) || s_tlast_i;
  assign out_free   = !out_valid_q || m_tready_i;
  assign s_tready_o = !rst && (!completes || out_free);
  assign accept     = s_tvalid_i && s_tready_o;

  // Lanes above the current one are forced empty in the closing word.
  always_comb begin
    pack_data_d = pack_data_q;
    pack_keep_d = pack_keep_q;
    word_data   = '0;
    word_keep   = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (LW'(i) == lane_q) begin
        pack_data_d[i*IN_BITS +: IN_BITS] = s_tdata_i;
        pack_keep_d[i*KB +: KB]           = s_tkeep_i;
        word_data[i*IN_BITS +: IN_BITS]   = s_tdata_i;
        word_keep[i*KB +: KB]             = s_tkeep_i;
      end else if (LW'(i) < lane_q) begin
        word_data[i*IN_BITS +: IN_BITS] =
          pack_data_q[i*IN_BITS +: IN_BITS];
        word_keep[i*KB +: KB] = pack_keep_q[i*KB +: KB];
      end
    end
  end

  always_comb begin
    lane_d      = lane_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !m_tready_i;
    if (accept) begin
      if (completes) begin
        out_data_d  = word_data;
        out_keep_d  = word_keep;
        out_last_d  = s_tlast_i;
        out_valid_d = 1'b1;
        lane_d      = '0;
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q      <= '0;
      pack_data_q <= '0;
      pack_keep_q <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      if (accept && completes) begin
        pack_keep_q <= '0;
      end else if (accept) begin
        pack_data_q <= pack_data_d;
        pack_keep_q <= pack_keep_d;
      end
    end
  end

  assign m_tdata_o  = out_data_q;
  assign m_tkeep_o  = out_keep_q;
  assign m_tlast_o  = out_last_q;
  assign m_tvalid_o = out_valid_q;
endmodule

// File: rtl/comp_result_merger.sv
// comp_result_merger: round-robin merge of per-core compressed
// packets onto the wide host send stream.
module comp_result_merger
  import common::*;
#(
  parameter int N_CORES  = COMP_CORES,
  parameter int IN_BITS  = COMP_DATA_BITS,
  parameter int OUT_BITS = AXI_DATA_BITS,
  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CORES*IN_BITS-1:0]  in_tdata,
  input  logic [N_CORES*IN_BITS/8-1:0] in_tkeep,
  input  logic [N_CORES-1:0]          in_tlast,
  input  logic [N_CORES-1:0]          in_tvalid,
  output logic [N_CORES-1:0]          in_tready,
  output logic [OUT_BITS-1:0]         out_tdata,
  output logic [OUT_BITS/8-1:0]       out_tkeep,
  output logic                        out_tlast,
  output logic                        out_tvalid,
  input  logic                        out_tready,
  output logic [PW-1:0]               cur_core
);
  localparam int KB = IN_BITS / 8;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [IN_BITS-1:0] sel_data;
  logic [KB-1:0]      sel_keep;
  logic               sel_last, sel_valid, sel_ready;

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    in_tready = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (ptr_q == PW'(i)) begin
        sel_data     = in_tdata[i*IN_BITS +: IN_BITS];
        sel_keep     = in_tkeep[i*KB +: KB];
        sel_last     = in_tlast[i];
        sel_valid    = in_tvalid[i];
        in_tready[i] = sel_ready;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (sel_valid && sel_ready && sel_last) begin
      ptr_d = (ptr_q == PW'(N_CORES - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign cur_core = ptr_q;

  axis_lane_packer #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .s_tdata_i (sel_data),
    .s_tkeep_i (sel_keep),
    .s_tlast_i (sel_last),
    .s_tvalid_i(sel_valid),
    .s_tready_o(sel_ready),
    .m_tdata_o (out_tdata),
    .m_tkeep_o (out_tkeep),
    .m_tlast_o (out_tlast),
    .m_tvalid_o(out_tvalid),
    .m_tready_i(out_tready)
  );
endmodule

// File: tb/tb_comp_result_merger.sv
// Directed bench for comp_result_merger (4 cores, 128->512).
// Per-core beat FIFOs feed the DUT; a monitor logs host words.
module tb_comp_result_merger;
  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_tdata;
  logic [63:0]  in_tkeep;
  logic [3:0]   in_tlast, in_tvalid, in_tready;
  logic [511:0] out_tdata;
  logic [63:0]  out_tkeep;
  logic         out_tlast, out_tvalid, out_tready;
  logic [1:0]   cur_core;

  comp_result_merger dut (
    .clk(clk), .rst(rst),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep),
    .in_tlast(in_tlast), .in_tvalid(in_tvalid),
    .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep),
    .out_tlast(out_tlast), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .cur_core(cur_core)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [511:0] got,
                     input logic [511:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [127:0] bd [4][32];
  logic [15:0]  bk [4][32];
  logic         bl [4][32];
  int wp [4];
  int rp [4];

  logic [511:0] gd [64];
  logic [63:0]  gk [64];
  logic         gl [64];
  int           gc [64];
  int nout = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int onehot_viol = 0;
  int rdy2_seen = 0;

  function automatic logic [127:0] dat(input int c, input int i);
    dat = {4{8'hA0 + 8'(c), 8'(i), 16'h1234}};
  endfunction

  task automatic push(input int c, input logic [127:0] d,
                      input logic [15:0] k, input logic l);
    bd[c][wp[c] % 32] = d;
    bk[c][wp[c] % 32] = k;
    bl[c][wp[c] % 32] = l;
    wp[c]++;
  endtask

  always @(posedge clk) begin
    if ($countones(in_tready) > 1) onehot_viol++;
    if (in_tready[2]) rdy2_seen++;
    for (int c = 0; c < 4; c++) begin
      if (in_tvalid[c] && in_tready[c]) begin
        if (in_tlast[c]) last_acc_cyc = cyc;
        rp[c]++;
      end
    end
    if (!rst && out_tvalid && out_tready) begin
      gd[nout % 64] = out_tdata;
      gk[nout % 64] = out_tkeep;
      gl[nout % 64] = out_tlast;
      gc[nout % 64] = cyc;
      nout++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      in_tvalid[c] = (rp[c] != wp[c]);
      in_tdata[c*128 +: 128] = bd[c][rp[c] % 32];
      in_tkeep[c*16 +: 16]   = bk[c][rp[c] % 32];
      in_tlast[c]            = bl[c][rp[c] % 32];
    end
  end

  task automatic wait_out(input int n, input string tag);
    int b;
    b = 0;
    while (nout < n && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (nout < n) chk({tag, "_timeout"}, 512'(nout), 512'(n));
  endtask

  task automatic wait_acc(input int c, input int n, input string tag);
    int b;
    b = 0;
    while (rp[c] < n && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (rp[c] < n) chk({tag, "_timeout"}, 512'(rp[c]), 512'(n));
  endtask

  logic [511:0] w;
  int base;

  initial begin
    for (int c = 0; c < 4; c++) begin
      wp[c] = 0;
      rp[c] = 0;
      for (int j = 0; j < 32; j++) begin
        bd[c][j] = '0;
        bk[c][j] = '0;
        bl[c][j] = 1'b0;
      end
    end
    in_tdata = '0; in_tkeep = '0;
    in_tlast = '0; in_tvalid = '0;
    rst = 1'b1;
    out_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tready", 512'(in_tready), 512'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 512'(out_tvalid), 512'd0);
    chk("rst_tdata", out_tdata, 512'd0);
    chk("rst_tkeep", 512'(out_tkeep), 512'd0);
    chk("rst_core", 512'(cur_core), 512'd0);

    // core 0, four full beats
    for (int i = 0; i < 4; i++) push(0, dat(0, i), 16'hFFFF, i == 3);
    wait_out(1, "t1");
    w = {dat(0, 3), dat(0, 2), dat(0, 1), dat(0, 0)};
    chk("t1_data", gd[0], w);
    chk("t1_keep", 512'(gk[0]), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("t1_last", 512'(gl[0]), 512'd1);
    chk("t1_lat", 512'(gc[0]), 512'(last_acc_cyc + 1));
    chk("t1_core", 512'(cur_core), 512'd1);

    // core 1, partial last beat
    push(1, dat(1, 0), 16'hFFFF, 1'b0);
    push(1, dat(1, 1), 16'h00FF, 1'b1);
    wait_out(2, "t2");
    chk("t2_data", gd[1], {256'd0, dat(1, 1), dat(1, 0)});
    chk("t2_keep", 512'(gk[1]), 512'(64'h0000_0000_00FF_FFFF));
    chk("t2_last", 512'(gl[1]), 512'd1);

    // single-beat packets on 2 and 3 bring ptr back to 0
    push(2, dat(2, 0), 16'hFFFF, 1'b1);
    push(3, dat(3, 0), 16'h0F0F, 1'b1);
    wait_out(4, "t2b");
    chk("t2b_data", gd[2], {384'd0, dat(2, 0)});
    chk("t2b_keep", 512'(gk[3]), 512'(64'h0F0F));
    chk("t2b_core", 512'(cur_core), 512'd0);

    // all cores at once, two 1-beat packets each
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        push(c, dat(c, 10 + r), 16'hFFFF, 1'b1);
    wait_out(12, "t3");
    for (int k = 0; k < 8; k++)
      chk($sformatf("t3_ord%0d", k), gd[4 + k],
          {384'd0, dat(k % 4, 10 + k / 4)});
    chk("t3_onehot", 512'(onehot_viol), 512'd0);

    // output stall while core 0 sends eight beats
    out_tready = 1'b0;
    base = rp[0];
    for (int i = 0; i < 8; i++) push(0, dat(0, 20 + i), 16'hFFFF, i == 7);
    repeat (10) @(negedge clk);
    chk("t4_acc", 512'(rp[0] - base), 512'd7);
    chk("t4_valid", 512'(out_tvalid), 512'd1);
    w = {dat(0, 23), dat(0, 22), dat(0, 21), dat(0, 20)};
    chk("t4_hold", out_tdata, w);
    chk("t4_hlast", 512'(out_tlast), 512'd0);
    chk("t4_nout", 512'(nout), 512'd12);
    out_tready = 1'b1;
    wait_out(14, "t4");
    chk("t4_w1", gd[12], w);
    chk("t4_w1last", 512'(gl[12]), 512'd0);
    chk("t4_w2", gd[13], {dat(0, 27), dat(0, 26), dat(0, 25), dat(0, 24)});
    chk("t4_w2last", 512'(gl[13]), 512'd1);

    // active core 1 idle while core 2 waits
    rdy2_seen = 0;
    push(2, dat(2, 30), 16'hFFFF, 1'b1);
    repeat (20) @(negedge clk);
    chk("t5_rdy2", 512'(rdy2_seen), 512'd0);
    chk("t5_nout", 512'(nout), 512'd14);
    push(1, dat(1, 30), 16'hFFFF, 1'b1);
    wait_out(16, "t5");
    chk("t5_first", gd[14], {384'd0, dat(1, 30)});
    chk("t5_second", gd[15], {384'd0, dat(2, 30)});

    // reset mid-packet on core 0
    push(3, dat(3, 40), 16'hFFFF, 1'b1);
    wait_out(17, "t6a");
    chk("t6_core0", 512'(cur_core), 512'd0);
    push(0, dat(0, 40), 16'hFFFF, 1'b0);
    push(0, dat(0, 41), 16'hFFFF, 1'b0);
    wait_acc(0, wp[0], "t6acc");
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_rdy", 512'(in_tready), 512'd0);
    rst = 1'b0;
    chk("t6_valid", 512'(out_tvalid), 512'd0);
    chk("t6_ptr", 512'(cur_core), 512'd0);
    push(0, dat(0, 42), 16'hFFFF, 1'b1);
    wait_out(18, "t6");
    chk("t6_data", gd[17], {384'd0, dat(0, 42)});
    chk("t6_keep", 512'(gk[17]), 512'(64'hFFFF));
    chk("t6_last", 512'(gl[17]), 512'd1);
    chk("onehot", 512'(onehot_viol), 512'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/comp_result_merger.md
# comp_result_merger

Collects compressed output streams from the COMP_CORES compression cores and merges them, packet by packet, onto the single AXI_DATA_BITS host send stream. Packets are taken strictly in the same round-robin core order the input arbiter uses to dispatch them: core 0, 1, …, N_CORES-1, 0, …. Each core's narrow beats are packed into full-width host words. The block sits between the per-core compression outputs and `axis_host_send`.

## Interface
Parameters:
- `N_CORES`, default `COMP_CORES` (4): number of compression cores; ≥1.
- `IN_BITS`, default `COMP_DATA_BITS` (128): per-core stream data width.
- `OUT_BITS`, default `AXI_DATA_BITS` (512): host stream width; must be an integer multiple of `IN_BITS`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_tdata`  in  N_CORES*IN_BITS  core i occupies slice `[i*IN_BITS +: IN_BITS]`.
- `in_tkeep`  in  N_CORES*IN_BITS/8  per-core byte enables, sliced the same way.
- `in_tlast`  in  N_CORES  per-core end of packet.
- `in_tvalid`  in  N_CORES  per-core valid.
- `in_tready`  out  N_CORES  per-core ready; at most one bit is set at any time.
- `out_tdata`  out  OUT_BITS  packed host word.
- `out_tkeep`  out  OUT_BITS/8  byte enables of the host word.
- `out_tlast`  out  1  last host word of a core packet.
- `out_tvalid`  out  1  host word valid.
- `out_tready`  in  1  host sink ready.
- `cur_core`  out  $clog2(N_CORES) (min 1)  index of the core currently being drained.

## Operation
- Derived values:
  - `RATIO = OUT_BITS/IN_BITS` (4 by default).
  - `lane` counter, range 0..RATIO-1, is the next lane slot to fill in the pack register.
- `ptr` selects the active core. The block never asserts `in_tready` for any other core, and ignores `in_tvalid` from them.
- `completes = (lane == RATIO-1) || in_tlast[ptr]`.
- `in_tready[ptr] = !completes || out_free`, where `out_free = !out_tvalid || out_tready`.
- Non-completing beat accepted:
  - Its data goes into pack lane `lane`; its keep goes into the matching keep lane.
  - `lane` increments.
- Completing beat accepted:
  - The pack register plus this beat (in lane `lane`) load into the output register.
  - All lanes above `lane` get `tkeep = 0`; their data is don't-care and driven 0.
  - `out_tlast` is set to `in_tlast[ptr]`.
  - `lane` returns to 0.
  - The pack register's keep is cleared.
- A beat with `tlast` advances `ptr`: `ptr+1`, wrapping from N_CORES-1 to 0.
- Lane order: the first beat of a word lands in bits `[IN_BITS-1:0]`.
- A `tlast` beat with `tkeep = 0` is still a valid beat. It produces a word whose keep is the pack contents only, and `out_tlast = 1`.
- A packet never shares a host word with the next packet.
- `cur_core = ptr`.

## Timing
- Reset values:
  - `ptr = 0`, `lane = 0`.
  - `out_tvalid = 0`, `out_tlast = 0`, `out_tdata = 0`, `out_tkeep = 0`.
  - `in_tready = 0` during `rst`.
  - Reset mid-packet discards any partial pack and any held output word.
- Latency:
  - Completing beat accepted at cycle t → `out_tvalid` high at t+1.
  - Full throughput: 1 input beat per cycle when `out_tready` stays high.
- Output handshake:
  - While `out_tvalid && !out_tready`, `out_tdata`, `out_tkeep` and `out_tlast` hold stable.
  - During such a stall, non-completing beats may still be accepted; a completing beat is stalled.
- Simultaneous events: when the output word drains and a completing beat is accepted in the same cycle, the new word loads with no bubble.
- Idle core: when the active core has no valid beat, the block waits indefinitely and never skips ahead. Ordering is guaranteed, not fairness.
- `ptr` updates on the accepting edge. The next core can be served from the following cycle.

## Structure
- The shared package `common` holds `COMP_CORES`, `COMP_DATA_BITS`, `AXI_DATA_BITS` and the derived constant `COMP_RATIO = AXI_DATA_BITS/COMP_DATA_BITS`.
- The block is a thin core-select mux plus `ptr` logic around one sub-module, `axis_lane_packer`:
  - It takes one IN_BITS stream and produces one OUT_BITS stream.
  - It owns `lane`, the pack register and the output register.
  - It is reusable by the decompression path.

## Test plan
- Single packet, core 0, 4 full beats (keep all 1), `out_tready = 1` → one word with keep all 1 and `tlast = 1`, valid one cycle after the 4th beat; `cur_core` goes to 1.
- Core 1 packet of 2 beats, last with keep `0x00FF` → one word with keep `0x0000_0000_00FF_FFFF` and `tlast = 1`.
- All cores valid simultaneously with 1-beat packets, repeated twice → outputs ordered 0,1,2,3,0,1,2,3; only the `in_tready` bit of `ptr` is ever high.
- `out_tready` held low for 10 cycles while core 0 sends 7 beats → 4th beat's word held stable; beats 5-7 accepted into pack; 8th beat stalled until `out_tready` rises; no data loss or reorder.
- Core 2 valid but core 1 (active) idle for 20 cycles → `in_tready[2]` stays 0 and no output; the core 1 packet then flows first.
- `rst` pulsed after 2 beats of a core 0 packet → `out_tvalid = 0` and `ptr = 0` next cycle; a fresh 1-beat `tlast` packet produces a word containing only that beat in lane 0.
